// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the time-shared multiplier controller.
// The controller and its arbiter both import this package.
package mul_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W = 16;

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// It grants the first asserted request found when searching upward from ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gidx,
  output logic            any
);

  logic [IDW-1:0] idx_s;

  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    idx_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        gidx         = idx_s;
        any          = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one external combinational multiplier among NREQ requesters using round-robin grants.
// Only one operation is in flight at a time, and the product is returned to the requester that issued it.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]    req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]               resp_valid,
  input  logic [NREQ-1:0]               resp_ready,
  output logic [prod_w(WIDTH)-1:0]      resp_prod,
  output logic [WIDTH-1:0]              mul_in1,
  output logic [WIDTH-1:0]              mul_in2,
  input  logic [prod_w(WIDTH)-2:0]      mul_out,
  input  logic                          mul_ovf,
  output logic                          busy,
  output logic [CNT_W-1:0]              op_count
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = prod_w(WIDTH);

  state_e              state_q;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      gid_q;
  logic [WIDTH-1:0]    op_a_q;
  logic [WIDTH-1:0]    op_b_q;
  logic [PW-1:0]       prod_q;
  logic [NREQ-1:0]     resp_valid_q;
  logic                busy_q;
  logic [CNT_W-1:0]    op_count_q;

  logic [NREQ-1:0]     arb_grant_s;
  logic [IDW-1:0]      arb_gidx_s;
  logic                arb_any_s;
  logic [CNT_W-1:0]    op_count_d;
  logic [IDW-1:0]      rr_ptr_d;
  logic [NREQ-1:0]     gid_onehot_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant_s),
    .gidx  (arb_gidx_s),
    .any   (arb_any_s)
  );

  // Next-state values applied when a response is consumed.
  always_comb begin
    op_count_d   = op_count_q;
    rr_ptr_d     = rr_ptr_q;
    gid_onehot_s = NREQ'(1) << gid_q;
    if (op_count_q == {CNT_W{1'b1}}) begin
      op_count_d = op_count_q;
    end else begin
      op_count_d = op_count_q + CNT_W'(1);
    end
    if (gid_q == IDW'(NREQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = gid_q + IDW'(1);
    end
  end

  // Handshake acceptance is just "any grant", because the arbiter only grants valid requesters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gid_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      prod_q       <= '0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any_s) begin
            op_a_q  <= req_a[arb_gidx_s];
            op_b_q  <= req_b[arb_gidx_s];
            gid_q   <= arb_gidx_s;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          prod_q       <= {mul_ovf, mul_out};
          resp_valid_q <= gid_onehot_s;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready[gid_q]) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            prod_q       <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            rr_ptr_q     <= rr_ptr_d;
            op_count_q   <= op_count_d;
            state_q      <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          op_a_q       <= '0;
          op_b_q       <= '0;
          prod_q       <= '0;
          resp_valid_q <= '0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // req_ready is gated by rst_n so that it is zero immediately during an asynchronous reset.
  assign req_ready  = (state_q == IDLE && rst_n) ? arb_grant_s : '0;
  assign resp_valid = resp_valid_q;
  assign resp_prod  = prod_q;
  assign mul_in1    = op_a_q;
  assign mul_in2    = op_b_q;
  assign busy       = busy_q;
  assign op_count   = op_count_q;

endmodule
